// File: rtl/mode_counter.sv
// mode_counter: parametrised synchronous counter with run-time mode select
// (hold / up / down / bounce), programmable upper limit, parallel load and a
// registered terminal-count pulse. The zero and max flags are combinational.
module mode_counter #(
  parameter int WIDTH    = 4,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] limit,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] q,
  output logic             dir,
  output logic             tc,
  output logic             zero,
  output logic             max
);

  typedef enum logic [1:0] {
    MODE_HOLD   = 2'b00,
    MODE_UP     = 2'b01,
    MODE_DOWN   = 2'b10,
    MODE_BOUNCE = 2'b11
  } mode_t;

  // Direction doubles as the bounce FSM state; UP/DOWN force it too.
  typedef enum logic {
    RISE = 1'b0,
    FALL = 1'b1
  } dir_t;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] r_q;
  dir_t             r_state;
  logic             r_tc;

  logic [WIDTH-1:0] w_q_next;
  dir_t             w_state_next;
  logic             w_tc_next;

  logic [WIDTH-1:0] w_q_inc;
  logic [WIDTH-1:0] w_q_dec;
  logic             w_at_top;
  logic             w_at_zero;
  logic             w_limit_zero;
  mode_t            w_mode;

  assign w_q_inc      = r_q + ONE;
  assign w_q_dec      = r_q - ONE;
  assign w_at_top     = (r_q >= limit);
  assign w_at_zero    = (r_q == '0);
  assign w_limit_zero = (limit == '0);
  assign w_mode       = mode_t'(mode);

  // Next-state and terminal-count decode: load beats counting, counting needs enable.
  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch is inferred.
    w_q_next     = r_q;
    w_state_next = r_state;
    w_tc_next    = 1'b0;

    if (load) begin
      // Out-of-range load values are kept as-is; the count walks back in later.
      w_q_next     = load_value;
      w_state_next = RISE;
    end else if (enable) begin
      case (w_mode)
        MODE_UP: begin
          w_state_next = RISE;
          if (w_at_top) begin
            w_q_next  = SATURATE ? limit : '0;
            w_tc_next = 1'b1;
          end else begin
            w_q_next = w_q_inc;
          end
        end
        MODE_DOWN: begin
          w_state_next = FALL;
          if (w_at_zero) begin
            w_q_next  = SATURATE ? '0 : limit;
            w_tc_next = 1'b1;
          end else begin
            w_q_next = w_q_dec;
          end
        end
        MODE_BOUNCE: begin
          if (r_state == RISE) begin
            if (w_at_top) begin
              // Turn around; a zero limit pins the count at 0 while dir flips.
              w_state_next = FALL;
              w_q_next     = w_limit_zero ? '0 : w_q_dec;
              w_tc_next    = 1'b1;
            end else begin
              w_q_next = w_q_inc;
            end
          end else begin
            if (w_at_zero) begin
              w_state_next = RISE;
              w_q_next     = w_limit_zero ? '0 : w_q_inc;
              w_tc_next    = 1'b1;
            end else begin
              w_q_next = w_q_dec;
            end
          end
        end
        default: begin
          // MODE_HOLD: keep count and direction, tc drops.
        end
      endcase
    end
  end

  // State register with synchronous reset taking priority over everything.
  always_ff @(posedge clock) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      r_q     <= '0;
      r_state <= RISE;
      r_tc    <= 1'b0;
    end else begin
      r_q     <= w_q_next;
      r_state <= w_state_next;
      r_tc    <= w_tc_next;
    end
  end

  assign q    = r_q;
  assign dir  = r_state;
  assign tc   = r_tc;
  assign zero = w_at_zero;
  assign max  = w_at_top;

endmodule

// File: tb/tb_mode_counter.sv
// tb_mode_counter: drives a wrapping (SATURATE=0) and a clamping (SATURATE=1)
// instance with shared stimulus; a behavioural model predicts each edge and a
// monitor compares DUT outputs against the predicted values.
module tb_mode_counter;

  localparam int W = 4;
  localparam int M = 1 << W;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         enable = 1'b0;
  logic [1:0]   mode = 2'b00;
  logic [W-1:0] limit = '0;
  logic         load = 1'b0;
  logic [W-1:0] load_value = '0;

  logic [W-1:0] q0, q1;
  logic         dir0, dir1, tc0, tc1, zero0, zero1, max0, max1;

  mode_counter #(.WIDTH(W), .SATURATE(1'b0)) u_dut_wrap (
    .clock(clock), .reset(reset), .enable(enable), .mode(mode), .limit(limit),
    .load(load), .load_value(load_value),
    .q(q0), .dir(dir0), .tc(tc0), .zero(zero0), .max(max0)
  );

  mode_counter #(.WIDTH(W), .SATURATE(1'b1)) u_dut_sat (
    .clock(clock), .reset(reset), .enable(enable), .mode(mode), .limit(limit),
    .load(load), .load_value(load_value),
    .q(q1), .dir(dir1), .tc(tc1), .zero(zero1), .max(max1)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [W-1:0] q;
    logic         dir;
    logic         tc;
    logic         zero;
    logic         max;
  } obs_t;

  obs_t sb[2][$];

  int tests_run = 0;
  int tests_failed = 0;

  // Model state per instance (index 0 wraps, index 1 saturates).
  int m_q[2];
  int m_dir[2];
  int m_tc[2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Apply one cycle of inputs at the falling edge and predict the next edge.
  task automatic drive(input logic rst, input logic ld, input int lv, input logic en,
                       input int md, input int lim);
    obs_t e;
    @(negedge clock);
    reset      = rst;
    load       = ld;
    load_value = W'(lv);
    enable     = en;
    mode       = 2'(md);
    limit      = W'(lim);
    for (int s = 0; s < 2; s++) begin
      if (rst) begin
        m_q[s] = 0; m_dir[s] = 0; m_tc[s] = 0;
      end else if (ld) begin
        m_q[s] = lv; m_dir[s] = 0; m_tc[s] = 0;
      end else if (!en || md == 0) begin
        m_tc[s] = 0;
      end else if (md == 1) begin
        m_dir[s] = 0;
        if (m_q[s] >= lim) begin
          m_tc[s] = 1;
          m_q[s]  = (s == 1) ? lim : 0;
        end else begin
          m_tc[s] = 0;
          m_q[s]  = m_q[s] + 1;
        end
      end else if (md == 2) begin
        m_dir[s] = 1;
        if (m_q[s] == 0) begin
          m_tc[s] = 1;
          m_q[s]  = (s == 1) ? 0 : lim;
        end else begin
          m_tc[s] = 0;
          m_q[s]  = m_q[s] - 1;
        end
      end else begin
        int step;
        bit at_end;
        step   = (m_dir[s] != 0) ? -1 : 1;
        at_end = (m_dir[s] != 0) ? (m_q[s] == 0) : (m_q[s] >= lim);
        if (at_end) begin
          m_dir[s] = 1 - m_dir[s];
          m_tc[s]  = 1;
          m_q[s]   = (lim == 0) ? 0 : (m_q[s] - step + M) % M;
        end else begin
          m_tc[s]  = 0;
          m_q[s]   = (m_q[s] + step + M) % M;
        end
      end
      e.q    = W'(m_q[s]);
      e.dir  = m_dir[s][0];
      e.tc   = m_tc[s][0];
      e.zero = (m_q[s] == 0);
      e.max  = (m_q[s] >= lim);
      sb[s].push_back(e);
    end
  endtask

  // Monitor: after each rising edge, compare any predicted outputs.
  initial begin
    obs_t e;
    forever begin
      @(posedge clock);
      #1;
      if (sb[0].size() > 0) begin
        e = sb[0].pop_front();
        check("wrap.q",    32'(q0),    32'(e.q));
        check("wrap.dir",  32'(dir0),  32'(e.dir));
        check("wrap.tc",   32'(tc0),   32'(e.tc));
        check("wrap.zero", 32'(zero0), 32'(e.zero));
        check("wrap.max",  32'(max0),  32'(e.max));
      end
      if (sb[1].size() > 0) begin
        e = sb[1].pop_front();
        check("sat.q",    32'(q1),    32'(e.q));
        check("sat.dir",  32'(dir1),  32'(e.dir));
        check("sat.tc",   32'(tc1),   32'(e.tc));
        check("sat.zero", 32'(zero1), 32'(e.zero));
        check("sat.max",  32'(max1),  32'(e.max));
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int lim, md, lv;
    logic rst, ld, en;

    // Reset state.
    drive(1, 0, 0, 0, 0, 9);
    drive(1, 0, 0, 0, 0, 9);

    // UP with limit 9: 0..9 then wrap (or clamp) with tc.
    for (int i = 0; i < 12; i++) drive(0, 0, 0, 1, 1, 9);

    // Reset mid-count for two edges, then count again from 0.
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 1, 1, 9);
    drive(1, 0, 0, 1, 1, 9);
    drive(1, 0, 0, 1, 1, 9);
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 1, 1, 9);

    // Load above limit wins over UP, then boundary step.
    drive(0, 1, 12, 1, 1, 9);
    drive(0, 0, 0, 1, 1, 9);
    drive(0, 0, 0, 1, 1, 9);

    // DOWN from 1 with limit 5.
    drive(0, 1, 1, 1, 2, 5);
    for (int i = 0; i < 4; i++) drive(0, 0, 0, 1, 2, 5);

    // BOUNCE with limit 3 from 0 rising.
    drive(0, 1, 0, 0, 3, 3);
    for (int i = 0; i < 9; i++) drive(0, 0, 0, 1, 3, 3);

    // Enable toggling with UP over the full range.
    drive(0, 1, 0, 0, 1, 15);
    for (int i = 0; i < 34; i++) drive(0, 0, 0, logic'(i % 2 == 0), 1, 15);

    // Zero limit in each counting mode.
    for (int m = 1; m < 4; m++)
      for (int i = 0; i < 3; i++) drive(0, 0, 0, 1, m, 0);

    // HOLD keeps q and dir but drops tc.
    drive(0, 0, 0, 1, 2, 4);
    drive(0, 0, 0, 1, 0, 4);
    drive(0, 0, 0, 1, 0, 4);

    // Randomised traffic with bias toward boundary limits.
    lim = 7;
    md  = 1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        case ($urandom_range(0, 3))
          0:       lim = 0;
          1:       lim = M - 1;
          default: lim = $urandom_range(0, M - 1);
        endcase
      end
      if ($urandom_range(0, 9) == 0) md = $urandom_range(0, 3);
      rst = ($urandom_range(0, 99) < 2);
      ld  = ($urandom_range(0, 99) < 6);
      en  = ($urandom_range(0, 99) < 80);
      lv  = $urandom_range(0, M - 1);
      drive(rst, ld, lv, en, md, lim);
    end

    @(negedge clock);
    @(negedge clock);
    check("sb.drained0", 32'(sb[0].size()), 32'd0);
    check("sb.drained1", 32'(sb[1].size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
